// File: rtl/cfg_bitstream_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : cfg_bitstream_loader_if
//  Brief    : valid/ready word stream feeding the configuration bitstream loader
//  Revision : 1.0  initial release
// ============================================================================
interface cfg_bitstream_loader_if #(
   parameter int WORD_W = 32
);
   logic [WORD_W-1:0] wdata;
   logic              wvalid;
   logic              wready;

   modport master (output wdata, output wvalid, input wready);
   modport slave  (input wdata, input wvalid, output wready);
endinterface
`default_nettype wire

// File: rtl/cfg_bitstream_loader.sv
`default_nettype none
// ============================================================================
//  Module   : cfg_bitstream_loader
//  Brief    : serialises bitstream words MSB-first onto the config chain head,
//             gates the chain clock and checks a CRC-16 over the shifted bits
//  Revision : 1.0  initial release
// ============================================================================
module cfg_bitstream_loader #(
   parameter int          WORD_W   = 32,
   parameter int          CNT_W    = 16,
   parameter logic [15:0] CRC_POLY = 16'h1021
) (
   input  wire logic             prog_clk,
   input  wire logic             reset,
   input  wire logic             start,
   input  wire logic [CNT_W-1:0] num_bits,
   input  wire logic [15:0]      exp_crc,
   cfg_bitstream_loader_if.slave wr,
   output logic                  fpga_head,
   output logic                  cfg_clk_en,
   output logic                  cfg_busy,
   output logic                  cfg_done,
   output logic                  cfg_crc_err
);

   localparam int                c_WL_W     = $clog2(WORD_W);
   localparam logic [CNT_W-1:0]  c_CNT_ONE  = 1;
   localparam logic [c_WL_W-1:0] c_WL_ONE   = 1;
   localparam logic [15:0]       c_CRC_INIT = 16'hFFFF;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_SHIFT = 2'd2,
      S_CHECK = 2'd3
   } state_t;

   state_t             r_state;
   logic [WORD_W-1:0]  r_buf;
   logic [CNT_W-1:0]   r_bits_left;
   logic [c_WL_W-1:0]  r_word_left;
   logic [15:0]        r_crc;
   logic [15:0]        r_exp_crc;

   logic               w_load;
   logic               w_word_msb;

   function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic bit_in);
      logic fb;
      fb = crc[15] ^ bit_in;
      return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
   endfunction

   // A word is taken either while stalled in FETCH or as a zero-bubble prefetch
   // during the last bit of the previous word (wready is only high then).
   assign w_load = ((r_state == S_FETCH) && wr.wvalid) ||
                   ((r_state == S_SHIFT) && (r_bits_left != '0) &&
                    (r_word_left == '0) && wr.wvalid && wr.wready);
   assign w_word_msb = wr.wdata[WORD_W-1];

   always_ff @(posedge prog_clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_buf       <= '0;
         r_bits_left <= '0;
         r_word_left <= '0;
         r_crc       <= c_CRC_INIT;
         r_exp_crc   <= '0;
         wr.wready   <= 1'b0;
         fpga_head   <= 1'b0;
         cfg_clk_en  <= 1'b0;
         cfg_busy    <= 1'b0;
         cfg_done    <= 1'b0;
         cfg_crc_err <= 1'b0;
      end else begin
         cfg_done <= 1'b0;
         if (w_load) begin
            r_state     <= S_SHIFT;
            fpga_head   <= w_word_msb;
            cfg_clk_en  <= 1'b1;
            r_buf       <= {wr.wdata[WORD_W-2:0], 1'b0};
            r_bits_left <= r_bits_left - c_CNT_ONE;
            r_word_left <= '1;
            r_crc       <= crc_step(r_crc, w_word_msb);
            wr.wready   <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (start) begin
                     cfg_crc_err <= 1'b0;
                     if (num_bits != '0) begin
                        r_bits_left <= num_bits;
                        r_exp_crc   <= exp_crc;
                        r_crc       <= c_CRC_INIT;
                        r_state     <= S_FETCH;
                        wr.wready   <= 1'b1;
                        cfg_busy    <= 1'b1;
                     end else begin
                        cfg_done <= 1'b1;
                     end
                  end
               end
               S_FETCH: begin
                  fpga_head  <= 1'b0;
                  cfg_clk_en <= 1'b0;
               end
               S_SHIFT: begin
                  if (r_bits_left == '0) begin
                     r_state     <= S_CHECK;
                     fpga_head   <= 1'b0;
                     cfg_clk_en  <= 1'b0;
                     wr.wready   <= 1'b0;
                     cfg_done    <= 1'b1;
                     cfg_crc_err <= (r_crc != r_exp_crc);
                  end else if (r_word_left == '0) begin
                     // Prefetch missed: freeze the chain until a word arrives.
                     r_state    <= S_FETCH;
                     fpga_head  <= 1'b0;
                     cfg_clk_en <= 1'b0;
                  end else begin
                     fpga_head   <= r_buf[WORD_W-1];
                     cfg_clk_en  <= 1'b1;
                     r_buf       <= {r_buf[WORD_W-2:0], 1'b0};
                     r_bits_left <= r_bits_left - c_CNT_ONE;
                     r_word_left <= r_word_left - c_WL_ONE;
                     r_crc       <= crc_step(r_crc, r_buf[WORD_W-1]);
                     wr.wready   <= (r_word_left == c_WL_ONE) && (r_bits_left != c_CNT_ONE);
                  end
               end
               S_CHECK: begin
                  r_state  <= S_IDLE;
                  cfg_busy <= 1'b0;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cfg_bitstream_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cfg_bitstream_loader
//  Brief    : directed self-checking bench for cfg_bitstream_loader
//  Revision : 1.0  initial release
// ============================================================================
module tb_cfg_bitstream_loader;

   logic        prog_clk = 1'b0;
   logic        reset    = 1'b0;
   logic        start    = 1'b0;
   logic [15:0] num_bits = '0;
   logic [15:0] exp_crc  = '0;
   logic        fpga_head, cfg_clk_en, cfg_busy, cfg_done, cfg_crc_err;

   int tests = 0;
   int fails = 0;

   cfg_bitstream_loader_if #(.WORD_W(32)) wr_if ();

   cfg_bitstream_loader #(.WORD_W(32), .CNT_W(16), .CRC_POLY(16'h1021)) dut (
      .prog_clk    (prog_clk),
      .reset       (reset),
      .start       (start),
      .num_bits    (num_bits),
      .exp_crc     (exp_crc),
      .wr          (wr_if),
      .fpga_head   (fpga_head),
      .cfg_clk_en  (cfg_clk_en),
      .cfg_busy    (cfg_busy),
      .cfg_done    (cfg_done),
      .cfg_crc_err (cfg_crc_err)
   );

   always #5 prog_clk = ~prog_clk;

   // Chain model plus per-load event counters, cleared by each accepted start.
   logic [63:0] chain = '0;
   int cyc = 0, start_cyc = 0, en_cnt = 0, hs_cnt = 0, wr_cnt = 0, done_cnt = 0;
   int first_en = 0, first_hs = 0, last_en = 0, done_cyc = 0, max_gap = 0;
   bit seen_en = 0, seen_hs = 0;

   always @(posedge prog_clk) begin
      cyc <= cyc + 1;
      if (start && !cfg_busy) begin
         en_cnt <= 0; hs_cnt <= 0; wr_cnt <= 0; done_cnt <= 0; max_gap <= 0;
         seen_en <= 0; seen_hs <= 0; start_cyc <= cyc;
      end else begin
         if (cfg_clk_en) begin
            chain  <= {chain[62:0], fpga_head};
            en_cnt <= en_cnt + 1;
            if (!seen_en) first_en <= cyc;
            else if (cyc - last_en - 1 > max_gap) max_gap <= cyc - last_en - 1;
            last_en <= cyc;
            seen_en <= 1;
         end
         if (wr_if.wvalid && wr_if.wready) begin
            hs_cnt <= hs_cnt + 1;
            if (!seen_hs) first_hs <= cyc;
            seen_hs <= 1;
         end
         if (wr_if.wready) wr_cnt <= wr_cnt + 1;
         if (cfg_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
         end
      end
   end

   task automatic do_load(input logic [15:0] nb, input logic [15:0] ec,
                          input logic [31:0] w0, input logic [31:0] w1,
                          input logic [31:0] w2, input int nw, input int gap);
      logic [31:0] w;
      int t;
      @(negedge prog_clk);
      start = 1'b1; num_bits = nb; exp_crc = ec;
      @(negedge prog_clk);
      start = 1'b0;
      for (int i = 0; i < nw; i++) begin
         w = (i == 0) ? w0 : ((i == 1) ? w1 : w2);
         if (i > 0 && gap > 0) begin
            wr_if.wvalid = 1'b0;
            t = 0;
            while (!wr_if.wready && t < 200) begin @(negedge prog_clk); t++; end
            repeat (gap) @(negedge prog_clk);
         end
         wr_if.wvalid = 1'b1;
         wr_if.wdata  = w;
         t = 0;
         while (!wr_if.wready && t < 200) begin @(negedge prog_clk); t++; end
         tests++;
         if (!wr_if.wready) begin
            fails++;
            $display("FAIL word_request_timeout: word %0d never requested", i);
         end
         @(negedge prog_clk);
      end
      // Decoy word stays valid to expose any request beyond the last needed word.
      wr_if.wvalid = 1'b1;
      wr_if.wdata  = 32'hA5A5A5A5;
      t = 0;
      while (done_cnt == 0 && t < 300) begin @(negedge prog_clk); t++; end
      tests++;
      if (done_cnt == 0) begin
         fails++;
         $display("FAIL done_timeout: no cfg_done within %0d cycles", t);
      end
      repeat (2) @(negedge prog_clk);
      wr_if.wvalid = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge prog_clk);
      tests++;
      if ({fpga_head, cfg_clk_en, wr_if.wready, cfg_busy, cfg_done, cfg_crc_err} !== 6'b0) begin
         fails++;
         $display("FAIL reset_outputs: got %b expected 000000",
                  {fpga_head, cfg_clk_en, wr_if.wready, cfg_busy, cfg_done, cfg_crc_err});
      end
      reset = 1'b1;
      repeat (2) @(negedge prog_clk);
      tests++;
      if ({wr_if.wready, cfg_busy, cfg_done} !== 3'b0) begin
         fails++;
         $display("FAIL idle_after_reset: got %b expected 000", {wr_if.wready, cfg_busy, cfg_done});
      end
   endtask

   task automatic test_back_to_back();
      do_load(16'd64, 16'h0000, 32'hDEADBEEF, 32'h01234567, 32'h0, 2, 0);
      tests++;
      if (chain !== 64'hDEADBEEF01234567) begin
         fails++; $display("FAIL b2b_chain: got %h expected DEADBEEF01234567", chain);
      end
      tests++;
      if (en_cnt != 64) begin fails++; $display("FAIL b2b_en_cnt: got %0d expected 64", en_cnt); end
      tests++;
      if (max_gap != 0) begin fails++; $display("FAIL b2b_gap: got %0d expected 0", max_gap); end
      tests++;
      if (done_cnt != 1) begin fails++; $display("FAIL b2b_done_cnt: got %0d expected 1", done_cnt); end
      tests++;
      if (first_en != first_hs + 1) begin
         fails++; $display("FAIL b2b_first_bit_latency: got %0d expected 1", first_en - first_hs);
      end
      tests++;
      if (done_cyc != last_en + 1) begin
         fails++; $display("FAIL b2b_done_latency: got %0d expected 1", done_cyc - last_en);
      end
      tests++;
      if (hs_cnt != 2) begin fails++; $display("FAIL b2b_words: got %0d expected 2", hs_cnt); end
      tests++;
      if (cfg_busy !== 1'b0) begin fails++; $display("FAIL b2b_busy_end: got %b expected 0", cfg_busy); end
   endtask

   task automatic test_stall_gap();
      do_load(16'd64, 16'h0000, 32'hDEADBEEF, 32'h01234567, 32'h0, 2, 5);
      tests++;
      if (chain !== 64'hDEADBEEF01234567) begin
         fails++; $display("FAIL gap_chain: got %h expected DEADBEEF01234567", chain);
      end
      tests++;
      if (max_gap != 5) begin fails++; $display("FAIL gap_len: got %0d expected 5", max_gap); end
      tests++;
      if (en_cnt != 64) begin fails++; $display("FAIL gap_en_cnt: got %0d expected 64", en_cnt); end
      tests++;
      if (done_cyc != last_en + 1) begin
         fails++; $display("FAIL gap_done_latency: got %0d expected 1", done_cyc - last_en);
      end
   endtask

   task automatic test_partial_word();
      do_load(16'd40, 16'h0000, 32'hDEADBEEF, 32'h01234567, 32'h0, 2, 0);
      tests++;
      if (chain[39:0] !== 40'hDEADBEEF01) begin
         fails++; $display("FAIL partial_chain: got %h expected DEADBEEF01", chain[39:0]);
      end
      tests++;
      if (en_cnt != 40) begin fails++; $display("FAIL partial_en_cnt: got %0d expected 40", en_cnt); end
      tests++;
      if (hs_cnt != 2) begin fails++; $display("FAIL partial_words: got %0d expected 2", hs_cnt); end
   endtask

   task automatic test_crc();
      // ASCII "123456789" (72 bits): CRC-16 poly 1021, init FFFF check value is 29B1.
      do_load(16'd72, 16'h29B1, 32'h31323334, 32'h35363738, 32'h39ABCDEF, 3, 0);
      tests++;
      if (cfg_crc_err !== 1'b0) begin fails++; $display("FAIL crc_good: got %b expected 0", cfg_crc_err); end
      tests++;
      if (en_cnt != 72) begin fails++; $display("FAIL crc_en_cnt: got %0d expected 72", en_cnt); end
      do_load(16'd72, 16'h29B0, 32'h31323334, 32'h35363738, 32'h39ABCDEF, 3, 0);
      tests++;
      if (cfg_crc_err !== 1'b1) begin fails++; $display("FAIL crc_bad: got %b expected 1", cfg_crc_err); end
      repeat (5) @(negedge prog_clk);
      tests++;
      if (cfg_crc_err !== 1'b1) begin fails++; $display("FAIL crc_sticky: got %b expected 1", cfg_crc_err); end
   endtask

   task automatic test_zero_bits();
      do_load(16'd0, 16'h0000, 32'h0, 32'h0, 32'h0, 0, 0);
      tests++;
      if (done_cnt != 1) begin fails++; $display("FAIL zero_done_cnt: got %0d expected 1", done_cnt); end
      tests++;
      if (done_cyc != start_cyc + 1) begin
         fails++; $display("FAIL zero_done_latency: got %0d expected 1", done_cyc - start_cyc);
      end
      tests++;
      if (en_cnt != 0) begin fails++; $display("FAIL zero_en_cnt: got %0d expected 0", en_cnt); end
      tests++;
      if (wr_cnt != 0) begin fails++; $display("FAIL zero_wready: got %0d expected 0", wr_cnt); end
      tests++;
      if (cfg_crc_err !== 1'b0) begin fails++; $display("FAIL zero_crc_clear: got %b expected 0", cfg_crc_err); end
   endtask

   task automatic test_reset_mid_load();
      int t;
      @(negedge prog_clk);
      start = 1'b1; num_bits = 16'd64; exp_crc = 16'h0000;
      @(negedge prog_clk);
      start = 1'b0;
      wr_if.wvalid = 1'b1; wr_if.wdata = 32'hDEADBEEF;
      @(negedge prog_clk);
      wr_if.wvalid = 1'b0;
      t = 0;
      while (en_cnt < 20 && t < 100) begin @(negedge prog_clk); t++; end
      reset = 1'b0;
      #1;
      tests++;
      if ({fpga_head, cfg_clk_en, wr_if.wready, cfg_busy, cfg_done, cfg_crc_err} !== 6'b0) begin
         fails++;
         $display("FAIL midreset_outputs: got %b expected 000000",
                  {fpga_head, cfg_clk_en, wr_if.wready, cfg_busy, cfg_done, cfg_crc_err});
      end
      repeat (3) @(negedge prog_clk);
      tests++;
      if (done_cnt != 0) begin fails++; $display("FAIL midreset_no_done: got %0d expected 0", done_cnt); end
      reset = 1'b1;
      @(negedge prog_clk);
      do_load(16'd64, 16'h0000, 32'h01234567, 32'hDEADBEEF, 32'h0, 2, 0);
      tests++;
      if (chain !== 64'h01234567DEADBEEF) begin
         fails++; $display("FAIL midreset_reload_chain: got %h expected 01234567DEADBEEF", chain);
      end
      tests++;
      if (en_cnt != 64) begin fails++; $display("FAIL midreset_reload_en: got %0d expected 64", en_cnt); end
   endtask

   initial begin
      wr_if.wvalid = 1'b0;
      wr_if.wdata  = '0;
      test_reset();
      test_back_to_back();
      test_stall_gap();
      test_partial_word();
      test_crc();
      test_zero_bits();
      test_reset_mid_load();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
